mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory between instruction fetch (IF) and load/store (D).
//  Sits between PC/Instruction fetch, the data-access stage and the unified memory model.
//  Sequences each access through an FSM.
//  Raises stall_o so the PC and control path hold while a requester waits.
// PARAMETERS
//  ADDR_W      32   address width
//  DATA_W      32   data width
//  STARVE_MAX  4    consecutive IF losses before IF is forced to win
//  TIMEOUT_CYC 16   BUSY cycles without mem_ack_i before abort (timeout build only)
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_i        in   1       reset, asynchronous, active-low
//  if_req_i     in   1       fetch request; held with if_addr_i until if_rvalid_o
//  if_addr_i    in   ADDR_W  fetch address
//  if_gnt_o     out  1       one-cycle pulse: fetch request accepted
//  if_rvalid_o  out  1       one-cycle pulse: if_rdata_o valid
//  if_rdata_o   out  DATA_W  fetched instruction
//  d_req_i      in   1       data request; held with d_we/addr/wdata until d_rvalid_o
//  d_we_i       in   1       1 = store, 0 = load
//  d_addr_i     in   ADDR_W  data address
//  d_wdata_i    in   DATA_W  store data
//  d_gnt_o      out  1       one-cycle pulse: data request accepted
//  d_rvalid_o   out  1       one-cycle pulse: load data valid or store done
//  d_rdata_o    out  DATA_W  load data
//  mem_req_o    out  1       memory request; held high until mem_ack_i
//  mem_we_o     out  1       memory write enable
//  mem_addr_o   out  ADDR_W  memory address
//  mem_wdata_o  out  DATA_W  memory write data
//  mem_ack_i    in   1       memory completion, one cycle
//  mem_rdata_i  in   DATA_W  memory read data, valid with mem_ack_i
//  stall_o      out  1       any pending request not completing this cycle
//  err_o        out  1       sticky timeout flag
// BEHAVIOUR
//  Reset: FSM=IDLE, starve_cnt=0, tmo_cnt=0.
//    All outputs 0, including mem_* buses, rdata buses and err_o.
//  FSM: IDLE -> BUSY_IF or BUSY_D when any request is pending.
//    BUSY_x -> IDLE on mem_ack_i, or on timeout (timeout build only).
//  Arbitration is evaluated in IDLE only:
//    D wins over IF, unless starve_cnt==STARVE_MAX; then IF wins.
//    starve_cnt increments when IF is pending and loses.
//    starve_cnt clears when IF wins, or when IF is not pending.
//  Grant: gnt_o pulses combinationally in the IDLE cycle the choice is made.
//    In that same edge, address, we and wdata are registered onto mem_*.
//    mem_req_o rises the next cycle.
//    IF grants always drive mem_we_o=0.
//  Completion: mem_ack_i in BUSY_x registers mem_rdata_i into x_rdata_o.
//    x_rvalid_o pulses the next cycle.
//    mem_req_o drops in that same next cycle, and the FSM returns to IDLE.
//    For stores, d_rdata_o = mem_rdata_i (don't-care for consumers).
//  Latency: request in cycle 0 with ack in cycle 1 gives rvalid in cycle 2.
//    Minimum 2 cycles; back-to-back accesses repeat every 3 cycles.
//  mem_ack_i outside BUSY: ignored.
//  Requests dropped before rvalid: protocol violation.
//    The access in flight still completes, and its rvalid is still issued.
//  stall_o = (if_req_i & ~if_rvalid_o) | (d_req_i & ~d_rvalid_o), combinational.
//  Reset asserted mid-access: immediate return to reset state.
//    No rvalid is issued for the aborted access.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//    tmo_cnt counts BUSY cycles and clears on entering BUSY.
//    At tmo_cnt==TIMEOUT_CYC-1 with no ack: mem_req_o drops, x_rvalid_o pulses with x_rdata_o=0.
//    Also err_o sets, and stays set until reset; FSM returns to IDLE.
//  Not defined: no counter; err_o tied 0; BUSY waits indefinitely for mem_ack_i.
// STRUCTURE
//  cpu_pkg: ADDR_W/DATA_W defaults.
//    Also the arb_state_t enum {IDLE, BUSY_IF, BUSY_D}.
//  Sub-module mem_arb_pick: priority choice plus starve_cnt register.
//    Outputs pick_if / pick_d.
//  Top: FSM, mem_* registers, response registers, timeout counter.
// TESTING
//  1. Reset: rst_i=0 for 3 cycles with if_req_i=1 -> all outputs 0, no gnt.
//  2. IF only: if_addr_i=0x0000_0010, ack one cycle after mem_req_o, mem_rdata_i=0x0050_0093.
//     Expect if_gnt_o in cycle 0, mem_addr_o=0x10 with mem_we_o=0.
//     Expect if_rvalid_o in cycle 2 with if_rdata_o=0x0050_0093.
//  3. Simultaneous if_req_i and d_req_i: d_gnt_o first.
//     Expect mem_we_o=1, d_addr_i=0x100 and wdata=0xDEAD_BEEF on the mem_* bus.
//     IF is granted after d_rvalid_o; stall_o stays 1 throughout.
//  4. Starvation: D re-requests every IDLE cycle while IF is held.
//     Expect IF granted on the 5th arbitration (STARVE_MAX=4); starve_cnt then returns to 0.
//  5. Timeout build: mem_ack_i never asserted.
//     Expect mem_req_o low after 16 BUSY cycles, d_rvalid_o pulse with d_rdata_o=0.
//     err_o=1 stays set; a later access completes normally.
//  6. rst_i low while in BUSY_D -> no d_rvalid_o; after release, FSM=IDLE and err_o=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side defaults and the arbiter state encoding.
package cpu_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority choice between fetch and data requesters, with the fetch
// starvation counter. Data normally wins; once fetch has lost STARVE_MAX
// arbitrations in a row it is forced to win the next one.
module mem_arb_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arb_en_i,
  input  logic if_pend_i,
  input  logic d_pend_i,
  output logic pick_if_o,
  output logic pick_d_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          if_forced;

  // Choose a winner and work out the next starvation count.
  always_comb begin
    if_forced = (starve_q == SW'(STARVE_MAX));
    pick_d_o  = arb_en_i & d_pend_i & ~(if_pend_i & if_forced);
    pick_if_o = arb_en_i & if_pend_i & ~pick_d_o;
    starve_d  = starve_q;
    if (arb_en_i) begin
      if (!if_pend_i || pick_if_o) begin
        starve_d = '0;
      end else if (pick_d_o) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and
// load/store (D), one access at a time through an IDLE/BUSY FSM.
// Optional build macro: MEM_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts
// an access after TIMEOUT_CYC cycles without mem_ack_i and sets sticky err_o.
//
// Handshake: a requester raises x_req_i with its address/data and holds them
// until x_rvalid_o. x_gnt_o pulses (combinationally) in the IDLE cycle the
// request is chosen; mem_req_o rises the next cycle and stays high until the
// cycle mem_ack_i is seen; x_rvalid_o pulses the cycle after the ack. No
// arbitration happens in a cycle where an rvalid pulses, so a still-high
// request in that cycle is not mistaken for a new one.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter int DATA_W     = CPU_DATA_W,
  parameter int STARVE_MAX = 4
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              err_o,
  output logic [1:0]        dbg_state_o
);

  arb_state_t        state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_rvalid_q;
  logic              d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              arb_en;
  logic              pick_if;
  logic              pick_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
`endif

  // Arbitrate only when idle, out of reset and not in a response cycle.
  assign arb_en = rst_i & (state_q == IDLE) & ~if_rvalid_q & ~d_rvalid_q;

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .arb_en_i (arb_en),
    .if_pend_i(if_req_i),
    .d_pend_i (d_req_i),
    .pick_if_o(pick_if),
    .pick_d_o (pick_d)
  );

  // Access sequencer: grant capture, completion, optional watchdog abort.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
          tmo_q <= '0;
`endif
          if (pick_d) begin
            state_q     <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we_i;
            mem_addr_q  <= d_addr_i;
            mem_wdata_q <= d_wdata_i;
          end else if (pick_if) begin
            state_q     <= BUSY_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr_i;
            mem_wdata_q <= '0;
          end
        end
        BUSY_IF, BUSY_D: begin
          if (mem_ack_i) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            if (state_q == BUSY_IF) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata_i;
            end else begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= mem_rdata_i;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            if (state_q == BUSY_IF) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= '0;
            end else begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= '0;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_gnt_o    = pick_if;
  assign d_gnt_o     = pick_d;
  assign if_rvalid_o = if_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign dbg_state_o = state_q;

  // Outputs read zero while reset is held, stall included.
  assign stall_o = rst_i & ((if_req_i & ~if_rvalid_q) | (d_req_i & ~d_rvalid_q));

`ifdef MEM_ARB_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: per-cycle vector table plus hand sequences for
// reset, starvation, watchdog (MEM_ARB_TIMEOUT_EN) and mid-access reset.
module tb_mem_port_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic        err_o;
  logic [1:0]  dbg_state_o;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] exp_q[$];

  mem_port_arbiter dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_gnt_o   (if_gnt_o),
    .if_rvalid_o(if_rvalid_o),
    .if_rdata_o (if_rdata_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_gnt_o    (d_gnt_o),
    .d_rvalid_o (d_rvalid_o),
    .d_rdata_o  (d_rdata_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (mem_ack_i),
    .mem_rdata_i(mem_rdata_i),
    .stall_o    (stall_o),
    .err_o      (err_o),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and watchdog
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // Per-cycle vector: inputs applied for one cycle, outputs expected mid-cycle.
  // flags layout: {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, stall, err}
  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        ack;
    logic [31:0] rdata;
    logic [7:0]  flags;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] ifrd;
    logic [31:0] drd;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                              input logic ak, input logic [31:0] rd, input logic [7:0] fl,
                              input logic [31:0] ma, input logic [31:0] mwd,
                              input logic [31:0] ird, input logic [31:0] drdv);
    vec_t v;
    v.if_req = ir;  v.if_addr = ia;  v.d_req = dr;   v.d_we = dw;
    v.d_addr = da;  v.d_wdata = dwd; v.ack = ak;     v.rdata = rd;
    v.flags = fl;   v.maddr = ma;    v.mwdata = mwd; v.ifrd = ird; v.drd = drdv;
    return v;
  endfunction

  function automatic logic [31:0] flags();
    return {24'b0, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o,
            mem_req_o, mem_we_o, stall_o, err_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: event not seen within cycle budget", name);
  endtask

  task automatic idle_inputs();
    if_req_i = 1'b0; if_addr_i = '0; d_req_i = 1'b0; d_we_i = 1'b0;
    d_addr_i = '0;   d_wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
  endtask

  // Driver: one access with a memory that acks whenever mem_req_o is high.
  task automatic run_access(input logic is_d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] resp,
                            output logic [31:0] got, output logic ok);
    ok = 1'b0;
    got = '0;
    if (is_d) begin
      d_req_i = 1'b1; d_we_i = we; d_addr_i = addr; d_wdata_i = wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = addr;
    end
    for (int c = 0; c < 20; c++) begin
      mem_ack_i   = mem_req_o;
      mem_rdata_i = resp;
      @(negedge clk_i);
      if (is_d ? d_rvalid_o : if_rvalid_o) begin
        got = is_d ? d_rdata_o : if_rdata_o;
        ok  = 1'b1;
      end
      @(posedge clk_i); #1;
      if (ok) break;
    end
    idle_inputs();
  endtask

  initial begin
    logic [31:0] got;
    logic        ok;
    logic        done;
    logic [31:0] e;
    logic [31:0] last_resp;
    int          busy;
    int          k;

    // Reset held 3 cycles with a fetch request present.
    idle_inputs();
    rst_i = 1'b0;
    if_req_i = 1'b1;
    if_addr_i = 32'h0000_0010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk($sformatf("rst%0d_flags", c), flags(), 32'h0);
      chk($sformatf("rst%0d_mem_addr", c), mem_addr_o, 32'h0);
      chk($sformatf("rst%0d_mem_wdata", c), mem_wdata_o, 32'h0);
      chk($sformatf("rst%0d_if_rdata", c), if_rdata_o, 32'h0);
      chk($sformatf("rst%0d_d_rdata", c), d_rdata_o, 32'h0);
      chk($sformatf("rst%0d_state", c), 32'(dbg_state_o), 32'd0);
    end
    @(posedge clk_i); #1;
    if_req_i = 1'b0;
    rst_i = 1'b1;

    // Vector table: IF only, simultaneous IF/D store, stray ack, D load.
    tbl[0]  = mk(1, 32'h10, 0, 0, 32'h0,   32'h0,         0, 32'h0,         8'b1000_0010, 32'h0,   32'h0,         32'h0,         32'h0);
    tbl[1]  = mk(1, 32'h10, 0, 0, 32'h0,   32'h0,         1, 32'h0050_0093, 8'b0000_1010, 32'h10,  32'h0,         32'h0,         32'h0);
    tbl[2]  = mk(1, 32'h10, 0, 0, 32'h0,   32'h0,         0, 32'h0,         8'b0010_0000, 32'h10,  32'h0,         32'h0050_0093, 32'h0);
    tbl[3]  = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,         0, 32'h0,         8'b0000_0000, 32'h10,  32'h0,         32'h0050_0093, 32'h0);
    tbl[4]  = mk(1, 32'h20, 1, 1, 32'h100, 32'hDEAD_BEEF, 0, 32'h0,         8'b0100_0010, 32'h10,  32'h0,         32'h0050_0093, 32'h0);
    tbl[5]  = mk(1, 32'h20, 1, 1, 32'h100, 32'hDEAD_BEEF, 1, 32'h1111_1111, 8'b0000_1110, 32'h100, 32'hDEAD_BEEF, 32'h0050_0093, 32'h0);
    tbl[6]  = mk(1, 32'h20, 1, 1, 32'h100, 32'hDEAD_BEEF, 0, 32'h0,         8'b0001_0110, 32'h100, 32'hDEAD_BEEF, 32'h0050_0093, 32'h1111_1111);
    tbl[7]  = mk(1, 32'h20, 0, 0, 32'h0,   32'h0,         0, 32'h0,         8'b1000_0110, 32'h100, 32'hDEAD_BEEF, 32'h0050_0093, 32'h1111_1111);
    tbl[8]  = mk(1, 32'h20, 0, 0, 32'h0,   32'h0,         1, 32'hCAFE_F00D, 8'b0000_1010, 32'h20,  32'h0,         32'h0050_0093, 32'h1111_1111);
    tbl[9]  = mk(1, 32'h20, 0, 0, 32'h0,   32'h0,         0, 32'h0,         8'b0010_0000, 32'h20,  32'h0,         32'hCAFE_F00D, 32'h1111_1111);
    tbl[10] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,         1, 32'h5555_5555, 8'b0000_0000, 32'h20,  32'h0,         32'hCAFE_F00D, 32'h1111_1111);
    tbl[11] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,         0, 32'h0,         8'b0000_0000, 32'h20,  32'h0,         32'hCAFE_F00D, 32'h1111_1111);
    tbl[12] = mk(0, 32'h0,  1, 0, 32'h104, 32'h0,         0, 32'h0,         8'b0100_0010, 32'h20,  32'h0,         32'hCAFE_F00D, 32'h1111_1111);
    tbl[13] = mk(0, 32'h0,  1, 0, 32'h104, 32'h0,         1, 32'h1234_5678, 8'b0000_1010, 32'h104, 32'h0,         32'hCAFE_F00D, 32'h1111_1111);
    tbl[14] = mk(0, 32'h0,  1, 0, 32'h104, 32'h0,         0, 32'h0,         8'b0001_0000, 32'h104, 32'h0,         32'hCAFE_F00D, 32'h1234_5678);
    tbl[15] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,         0, 32'h0,         8'b0000_0000, 32'h104, 32'h0,         32'hCAFE_F00D, 32'h1234_5678);

    for (int i = 0; i < 16; i++) begin
      if_req_i = tbl[i].if_req;   if_addr_i = tbl[i].if_addr;
      d_req_i = tbl[i].d_req;     d_we_i = tbl[i].d_we;
      d_addr_i = tbl[i].d_addr;   d_wdata_i = tbl[i].d_wdata;
      mem_ack_i = tbl[i].ack;     mem_rdata_i = tbl[i].rdata;
      @(negedge clk_i);
      chk($sformatf("vec%0d_flags", i), flags(), {24'b0, tbl[i].flags});
      chk($sformatf("vec%0d_mem_addr", i), mem_addr_o, tbl[i].maddr);
      chk($sformatf("vec%0d_if_rdata", i), if_rdata_o, tbl[i].ifrd);
      chk($sformatf("vec%0d_d_rdata", i), d_rdata_o, tbl[i].drd);
      if (tbl[i].flags[2]) chk($sformatf("vec%0d_mem_wdata", i), mem_wdata_o, tbl[i].mwdata);
      @(posedge clk_i); #1;
    end
    idle_inputs();

    // Starvation: D always requesting, IF held. Expected grant order, 1 = D, 0 = IF.
    exp_q = {};
    repeat (4) exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    if_req_i = 1'b1; if_addr_i = 32'h40;
    d_req_i = 1'b1;  d_we_i = 1'b0; d_addr_i = 32'h200;
    done = 1'b0; k = 0; last_resp = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      mem_ack_i   = mem_req_o;
      mem_rdata_i = 32'h1000 + 32'(c);
      if (mem_ack_i) last_resp = mem_rdata_i;
      @(negedge clk_i);
      if (if_gnt_o || d_gnt_o) begin
        if (exp_q.size() == 0) begin
          fail_now("starve_extra_grant");
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("starve_grant%0d_is_d", k), 32'(d_gnt_o), e);
          if (if_gnt_o) chk("starve_cnt_at_if_win", 32'(dut.u_pick.starve_q), 32'd4);
        end
        k++;
      end
      if (if_rvalid_o) begin
        done = 1'b1;
        chk("starve_if_rdata", if_rdata_o, last_resp);
        chk("starve_cnt_cleared", 32'(dut.u_pick.starve_q), 32'd0);
      end
      @(posedge clk_i); #1;
    end
    if (!done) fail_now("starve_if_rvalid");
    chk("starve_grants_left", 32'(exp_q.size()), 32'd0);
    idle_inputs();
    @(posedge clk_i); #1;

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: load never acked, aborted after 16 BUSY cycles.
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300;
    busy = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk_i);
      if (mem_req_o) busy++;
      if (d_rvalid_o) begin
        done = 1'b1;
        chk("tmo_busy_cycles", 32'(busy), 32'd16);
        chk("tmo_d_rdata", d_rdata_o, 32'h0);
        chk("tmo_mem_req", 32'(mem_req_o), 32'd0);
        chk("tmo_err", 32'(err_o), 32'd1);
      end
      @(posedge clk_i); #1;
    end
    if (!done) fail_now("tmo_d_rvalid");
    idle_inputs();
    @(posedge clk_i); #1;
    run_access(1'b0, 1'b0, 32'h44, 32'h0, 32'hA5A5_A5A5, got, ok);
    chk("tmo_after_ok", 32'(ok), 32'd1);
    chk("tmo_after_rdata", got, 32'hA5A5_A5A5);
    chk("tmo_err_sticky", 32'(err_o), 32'd1);
`else
    // No watchdog: an unacked access keeps mem_req_o high until acked.
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300;
    busy = 0; done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (mem_req_o) busy++;
      if (d_rvalid_o) done = 1'b1;
      @(posedge clk_i); #1;
    end
    chk("notmo_busy_cycles", 32'(busy), 32'd19);
    chk("notmo_no_rvalid", 32'(done), 32'd0);
    chk("notmo_err", 32'(err_o), 32'd0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0BAD_F00D;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("notmo_late_rvalid", 32'(d_rvalid_o), 32'd1);
    chk("notmo_late_rdata", d_rdata_o, 32'h0BAD_F00D);
    @(posedge clk_i); #1;
    idle_inputs();
    @(posedge clk_i); #1;
`endif

    // Reset asserted while a store is in BUSY_D.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h400; d_wdata_i = 32'h600D_CAFE;
    @(negedge clk_i);
    chk("rst6_d_gnt", 32'(d_gnt_o), 32'd1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rst6_busy_d", 32'(dbg_state_o), 32'd2);
    chk("rst6_mem_req", 32'(mem_req_o), 32'd1);
    #1 rst_i = 1'b0;
    #1;
    chk("rst6_async_flags", flags(), 32'h0);
    chk("rst6_async_addr", mem_addr_o, 32'h0);
    chk("rst6_async_state", 32'(dbg_state_o), 32'd0);
    d_req_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk($sformatf("rst6_post%0d_no_rvalid", c), 32'(d_rvalid_o), 32'd0);
      chk($sformatf("rst6_post%0d_state", c), 32'(dbg_state_o), 32'd0);
      chk($sformatf("rst6_post%0d_err", c), 32'(err_o), 32'd0);
      @(posedge clk_i); #1;
    end

    // Normal access after the aborted one.
    run_access(1'b1, 1'b0, 32'h408, 32'h0, 32'h7777_0001, got, ok);
    chk("post_rst_ok", 32'(ok), 32'd1);
    chk("post_rst_rdata", got, 32'h7777_0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
